// File: rtl/nand_page_reader.sv
// Read engine for small-block NAND flash A: issues 00h plus three address cycles, waits on R/B,
// then strobes one 512-byte page out through a single-entry holding register toward the NFC core.
module nand_page_reader #(
    parameter int T_WP       = 1,
    parameter int T_WH       = 1,
    parameter int T_WB       = 5,
    parameter int T_RP       = 2,
    parameter int T_REH      = 1,
    parameter int RB_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] page_addr,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rd_data,
    output logic [8:0] rd_col,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       rd_last,
    inout  wire  [7:0] F_IO,
    output logic       F_CLE,
    output logic       F_ALE,
    output logic       F_REN,
    output logic       F_WEN,
    input  logic       F_RB
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR0, S_ADDR1, S_ADDR2,
        S_WAIT_WB, S_WAIT_RB, S_RD_LOW, S_RD_HIGH, S_FINISH
    } state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] C_WP     = CW'(T_WP);
    localparam logic [CW-1:0] C_CMDEND = CW'(T_WP + T_WH - 1);
    localparam logic [CW-1:0] C_WBEND  = CW'(T_WB - 1);
    localparam logic [CW-1:0] C_RBEND  = CW'(RB_TIMEOUT - 1);
    localparam logic [CW-1:0] C_RPEND  = CW'(T_RP - 1);
    localparam logic [CW-1:0] C_REHEND = CW'(T_REH - 1);

    state_t        r_state, w_nextState;
    logic [CW-1:0] r_cnt, w_nextCnt;
    logic [8:0]    r_page, r_col, r_rdCol;
    logic [7:0]    r_rdData, r_ioOut, w_ioOutN;
    logic          r_rdValid, r_done, r_err;
    logic          r_cle, r_ale, r_wen, r_ren, r_ioOe;
    logic          w_latch, w_capture, w_colClear, w_done, w_err, w_handshake;
    logic          w_wrPhase, w_cleN, w_aleN, w_wenN, w_renN;

    assign w_handshake = r_rdValid && rd_ready;

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt + 1'b1;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        w_colClear  = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_nextCnt = '0;
                if (start) begin
                    w_latch     = 1'b1;
                    w_nextState = S_CMD;
                end
            end
            S_CMD:   if (r_cnt == C_CMDEND) begin w_nextCnt = '0; w_nextState = S_ADDR0;   end
            S_ADDR0: if (r_cnt == C_CMDEND) begin w_nextCnt = '0; w_nextState = S_ADDR1;   end
            S_ADDR1: if (r_cnt == C_CMDEND) begin w_nextCnt = '0; w_nextState = S_ADDR2;   end
            S_ADDR2: if (r_cnt == C_CMDEND) begin w_nextCnt = '0; w_nextState = S_WAIT_WB; end
            S_WAIT_WB: if (r_cnt == C_WBEND) begin w_nextCnt = '0; w_nextState = S_WAIT_RB; end
            S_WAIT_RB: begin
                if (F_RB) begin
                    w_nextCnt   = '0;
                    w_colClear  = 1'b1;
                    w_nextState = S_RD_LOW;
                end else if (r_cnt == C_RBEND) begin
                    w_nextCnt   = '0;
                    w_err       = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            S_RD_LOW: begin
                if (r_cnt == C_RPEND) begin
                    w_nextCnt   = '0;
                    w_capture   = 1'b1;
                    w_nextState = (r_col == 9'd511) ? S_FINISH : S_RD_HIGH;
                end
            end
            // REN stays high until both the minimum high time has elapsed and the holding register frees up.
            S_RD_HIGH: begin
                if (r_cnt >= C_REHEND) begin
                    w_nextCnt = r_cnt;
                    if (!r_rdValid || w_handshake) begin
                        w_nextCnt   = '0;
                        w_nextState = S_RD_LOW;
                    end
                end
            end
            S_FINISH: begin
                w_nextCnt = '0;
                if (w_handshake) begin
                    w_done      = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextCnt   = '0;
                w_nextState = S_IDLE;
            end
        endcase

        // Pin values are derived from the upcoming state so the registered pins line up with it.
        w_wrPhase = w_nextState inside {S_CMD, S_ADDR0, S_ADDR1, S_ADDR2};
        w_cleN    = (w_nextState == S_CMD);
        w_aleN    = w_nextState inside {S_ADDR0, S_ADDR1, S_ADDR2};
        w_wenN    = !(w_wrPhase && (w_nextCnt < C_WP));
        w_renN    = (w_nextState != S_RD_LOW);
        case (w_nextState)
            S_ADDR1: w_ioOutN = r_page[7:0];
            S_ADDR2: w_ioOutN = {7'b0, r_page[8]};
            default: w_ioOutN = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_page    <= '0;
            r_col     <= '0;
            r_rdData  <= '0;
            r_rdCol   <= '0;
            r_rdValid <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cle     <= 1'b0;
            r_ale     <= 1'b0;
            r_wen     <= 1'b1;
            r_ren     <= 1'b1;
            r_ioOe    <= 1'b0;
            r_ioOut   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (w_latch) r_page <= page_addr;
            if (w_colClear) r_col <= '0;
            else if (w_capture) r_col <= r_col + 1'b1;
            if (w_capture) begin
                r_rdData  <= F_IO;
                r_rdCol   <= r_col;
                r_rdValid <= 1'b1;
            end else if (w_handshake) begin
                r_rdValid <= 1'b0;
            end
            r_done  <= w_done;
            r_err   <= w_err;
            r_cle   <= w_cleN;
            r_ale   <= w_aleN;
            r_wen   <= w_wenN;
            r_ren   <= w_renN;
            r_ioOe  <= w_wrPhase;
            r_ioOut <= w_ioOutN;
        end
    end

    assign F_IO     = r_ioOe ? r_ioOut : 8'hzz;
    assign F_CLE    = r_cle;
    assign F_ALE    = r_ale;
    assign F_WEN    = r_wen;
    assign F_REN    = r_ren;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign err      = r_err;
    assign rd_data  = r_rdData;
    assign rd_col   = r_rdCol;
    assign rd_valid = r_rdValid;
    assign rd_last  = r_rdValid && (r_rdCol == 9'd511);

endmodule

// File: tb/tb_nand_page_reader.sv
// Directed bench for nand_page_reader with a behavioural small-block flash model on the pin side.
module tb_nand_page_reader;

    localparam int T_WB       = 5;
    localparam int RB_TIMEOUT = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [8:0] page_addr = '0;
    logic       rd_ready = 1'b0;
    logic       busy, done, err, rd_valid, rd_last;
    logic [7:0] rd_data;
    logic [8:0] rd_col;
    wire  [7:0] F_IO;
    logic       F_CLE, F_ALE, F_REN, F_WEN, F_RB;

    int checks = 0;
    int failures = 0;

    nand_page_reader #(
        .T_WP(1), .T_WH(1), .T_WB(T_WB), .T_RP(2), .T_REH(1), .RB_TIMEOUT(RB_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .page_addr(page_addr),
        .busy(busy), .done(done), .err(err),
        .rd_data(rd_data), .rd_col(rd_col), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .F_IO(F_IO), .F_CLE(F_CLE), .F_ALE(F_ALE), .F_REN(F_REN), .F_WEN(F_WEN), .F_RB(F_RB)
    );

    always #10 clk = ~clk;

    // Flash contents: page 0 holds k[7:0] at column k; other pages are scrambled by page number.
    function automatic logic [7:0] memByte(input logic [8:0] page, input int col);
        logic [8:0] c;
        c = col[8:0];
        return c[7:0] ^ page[7:0] ^ {page[8], 7'b0};
    endfunction

    logic       rbStuck = 1'b0;
    int         rbDelay = 20;
    int         rbCnt = 0;
    int         addrCnt = 0;
    int         ptr = 0;
    logic [7:0] addrBytes [3] = '{default: 8'h00};
    logic       prevWenM = 1'b1;
    logic       prevRenM = 1'b1;
    wire  [8:0] modelPage = {addrBytes[2][0], addrBytes[1]};

    assign F_IO = (!F_REN) ? memByte(modelPage, ptr) : 8'hzz;
    assign F_RB = !rbStuck && (rbCnt == 0);

    // Flash model latches cycles on WEN rise, goes busy after the third address, advances on REN rise.
    always @(posedge clk) begin
        if (F_WEN && !prevWenM) begin
            if (F_CLE) begin
                addrCnt <= 0;
            end else if (F_ALE) begin
                if (addrCnt < 3) addrBytes[addrCnt] <= F_IO;
                addrCnt <= addrCnt + 1;
                if (addrCnt == 2) begin
                    ptr   <= 0;
                    rbCnt <= rbDelay;
                end
            end
        end else if (rbCnt > 0) begin
            rbCnt <= rbCnt - 1;
        end
        if (F_REN && !prevRenM) ptr <= ptr + 1;
        prevWenM <= F_WEN;
        prevRenM <= F_REN;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkIdlePins(input bit checkData);
        checkOutput("idleCle", 32'(F_CLE), 32'd0);
        checkOutput("idleAle", 32'(F_ALE), 32'd0);
        checkOutput("idleRen", 32'(F_REN), 32'd1);
        checkOutput("idleWen", 32'(F_WEN), 32'd1);
        checkOutput("idleIoZ", {24'h0, F_IO}, {24'h0, 8'hzz});
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("idleDone", 32'(done), 32'd0);
        checkOutput("idleErr", 32'(err), 32'd0);
        checkOutput("idleValid", 32'(rd_valid), 32'd0);
        if (checkData) begin
            checkOutput("idleData", 32'(rd_data), 32'd0);
            checkOutput("idleCol", 32'(rd_col), 32'd0);
        end
    endtask

    // Runs one full page read; readyMode 0 = always ready, 1 = ready one cycle in four.
    task automatic applyStimulus(input logic [8:0] page, input int readyMode, input bit holdStart);
        logic [9:0] busLog [8] = '{default: 10'h0};
        int         nb = 0;
        int         expCol = 0;
        int         cyc = 0;
        int         lastHs = -10;
        int         bad = 0;
        int         heldPulse = 0;
        bit         doneSeen = 1'b0;
        bit         stalled = 1'b0;
        logic [7:0] heldData = '0;
        logic [8:0] heldCol = '0;
        logic       prevWen = 1'b1;
        page_addr = page;
        start     = 1'b1;
        rd_ready  = 1'b0;
        @(posedge clk); #1;
        if (!holdStart) start = 1'b0;
        checkOutput("busyAfterStart", 32'(busy), 32'd1);
        while (!doneSeen && cyc < 12000) begin
            if (F_WEN && !prevWen && nb < 8) begin
                busLog[nb] = {F_CLE, F_ALE, F_IO};
                nb++;
            end
            prevWen = F_WEN;
            if ((!F_WEN && !F_REN) || (F_CLE && F_ALE)) bad++;
            if (rd_valid && !F_REN) heldPulse++;
            if (stalled && (rd_data !== heldData || rd_col !== heldCol || rd_valid !== 1'b1)) bad++;
            if (done) begin
                doneSeen = 1'b1;
                checkOutput("doneLatency", cyc, lastHs + 1);
                checkOutput("busyAtDone", 32'(busy), 32'd0);
            end else begin
                if (holdStart) start = (cyc != 300);
                rd_ready = (readyMode == 0) ? 1'b1 : (cyc % 4 == 0);
                stalled  = rd_valid && !rd_ready;
                heldData = rd_data;
                heldCol  = rd_col;
                if (rd_valid && rd_ready) begin
                    checkOutput("rdCol", 32'(rd_col), expCol);
                    checkOutput("rdData", 32'(rd_data), 32'(memByte(page, expCol)));
                    checkOutput("rdLast", 32'(rd_last), 32'(expCol == 511));
                    expCol++;
                    lastHs = cyc;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        rd_ready = 1'b0;
        checkOutput("doneSeen", 32'(doneSeen), 32'd1);
        checkOutput("bytesDelivered", expCol, 512);
        checkOutput("busCycles", nb, 4);
        checkOutput("busCmd", 32'(busLog[0]), {22'h0, 2'b10, 8'h00});
        checkOutput("busAddr0", 32'(busLog[1]), {22'h0, 2'b01, 8'h00});
        checkOutput("busAddr1", 32'(busLog[2]), {22'h0, 2'b01, page[7:0]});
        checkOutput("busAddr2", 32'(busLog[3]), {22'h0, 2'b01, 7'b0, page[8]});
        checkOutput("pinRulesAndStall", bad, 0);
        checkOutput("renWhileHeld", heldPulse, 0);
    endtask

    initial begin
        int  cyc;
        int  cA;
        int  errCyc;
        int  renLow;
        int  doneCnt;
        bit  found;
        logic prevAle;

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        checkIdlePins(1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] page 0, always ready");
        applyStimulus(9'd0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] page 511, ready one cycle in four");
        applyStimulus(9'd511, 1, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] R/B stuck busy");
        rbStuck   = 1'b1;
        page_addr = 9'd7;
        start     = 1'b1;
        rd_ready  = 1'b1;
        cyc = 0; cA = -1; errCyc = -1; renLow = 0; doneCnt = 0; prevAle = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (errCyc < 0 && cyc < 6000) begin
            if (prevAle && !F_ALE) cA = cyc;
            prevAle = F_ALE;
            if (!F_REN) renLow++;
            if (done) doneCnt++;
            if (err) begin
                errCyc = cyc;
                checkOutput("busyAtErr", 32'(busy), 32'd0);
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checkOutput("errLatency", errCyc, cA + T_WB + RB_TIMEOUT);
        checkOutput("renDuringTimeout", renLow, 0);
        checkOutput("doneDuringTimeout", doneCnt, 0);
        @(posedge clk); #1;
        checkOutput("errOneCycle", 32'(err), 32'd0);
        rbStuck  = 1'b0;
        rd_ready = 1'b0;

        $display("[TB] reset at column 100, then page 3");
        page_addr = 9'd5;
        start     = 1'b1;
        rd_ready  = 1'b1;
        cyc = 0; found = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (!found && cyc < 3000) begin
            if (rd_valid && rd_col == 9'd100) found = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checkOutput("reachedCol100", 32'(found), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        checkIdlePins(1'b0);
        rst      = 1'b1;
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(9'd3, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] start held high with mid-transfer re-pulse");
        applyStimulus(9'd9, 0, 1'b1);
        @(posedge clk); #1;
        checkOutput("restartFromIdle", 32'(busy), 32'd1);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checkOutput("abortBusy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nand_page_reader.md
Name: nand_page_reader

Overview:
- Flash-side read engine for the NFC: fetches one 512-byte page from small-block NAND flash A and streams its bytes to the NFC copy core, which then programs them into flash B.
- Sits between the NFC core (upstream requester and downstream data consumer) and the flash_a pins.
- Handles the command and address cycle sequence, R/B wait and timeout, read-strobe timing, and byte-stream backpressure.

Parameters:
T_WP, 1, WEN low cycles per command/address byte (>=1)
T_WH, 1, WEN high cycles after each command/address byte (>=1)
T_WB, 5, cycles after the last address WEN rise before F_RB is sampled
T_RP, 2, REN low cycles per data byte (>=1)
T_REH, 1, minimum REN high cycles between data bytes (>=1)
RB_TIMEOUT, 4096, maximum cycles to wait for F_RB high

Ports:
clk  in  1  system clock (20 ns)
rst  in  1  synchronous reset, active-low
start  in  1  request page read; sampled only in IDLE
page_addr  in  9  page number 0..511; latched on accepted start
busy  out  1  high from accepted start until return to IDLE
done  out  1  1-cycle pulse after byte 511 is accepted
err  out  1  1-cycle pulse on R/B timeout
rd_data  out  8  captured flash byte
rd_col  out  9  column index of rd_data
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts when rd_valid && rd_ready
rd_last  out  1  rd_valid && rd_col==511
F_IO  inout  8  flash data bus; driven only during command/address, else high-Z
F_CLE  out  1  command latch enable
F_ALE  out  1  address latch enable
F_REN  out  1  read enable, active-low
F_WEN  out  1  write enable, active-low
F_RB  in  1  flash ready(1)/busy(0)

Behaviour:
- Reset (rst==0 at posedge): state IDLE. Outputs: F_CLE=0, F_ALE=0, F_REN=1, F_WEN=1, F_IO high-Z, busy=0, done=0, err=0, rd_valid=0, rd_data=0, rd_col=0. Reset during any state aborts the operation with no done or err pulse.
- States: IDLE -> CMD -> ADDR0 -> ADDR1 -> ADDR2 -> WAIT_WB -> WAIT_RB -> RD_LOW -> RD_HIGH -> (RD_LOW | FINISH) -> IDLE.
- IDLE: when start==1, latch page_addr, set busy=1 on the next cycle, and go to CMD. start is ignored while busy.
- CMD: F_CLE=1 and F_IO=8'h00 throughout. F_WEN=0 for T_WP cycles, then F_WEN=1 for T_WH cycles. CLE and IO are held through the WEN-high phase.
- ADDR0/1/2: F_ALE=1, CLE=0, with the same WEN timing as CMD. Address bytes: ADDR0=8'h00 (column), ADDR1=page[7:0], ADDR2={7'b0,page[8]}. ALE drops and IO is released on exit from ADDR2.
- WAIT_WB: count T_WB cycles; F_RB is ignored.
- WAIT_RB: count cycles. First cycle with F_RB==1 -> RD_LOW with column=0. If the count reaches RB_TIMEOUT first: err pulse, busy=0, go to IDLE.
- RD_LOW: F_REN=0 for T_RP cycles. At the edge ending the last low cycle, capture F_IO into rd_data and set rd_col=current column. rd_valid=1 from the following cycle.
- RD_HIGH: F_REN=1 for at least T_REH cycles. Leave for RD_LOW only when the holding register is free, i.e. rd_valid==0 or a handshake occurs that cycle. Column increments on each capture.
- Single-entry holding register: rd_data, rd_col and rd_valid stay stable until the handshake. rd_valid drops the cycle after the handshake unless a new capture occurs on the same edge.
- After capturing column 511, issue no further REN pulses. FINISH waits for the handshake of byte 511, then pulses done, drops busy, and returns to IDLE on the same edge.
- The flash reads sequentially across the 00h half boundary; no 01h command is issued.
- F_IO output enable and F_CLE/F_ALE/F_WEN/F_REN are registered, so there are no combinational glitches on flash pins.
- F_WEN and F_REN are never low simultaneously. CLE and ALE are never both high.

Test Plan:
- page_addr=0, start pulse, rd_ready=1, flash_a holding byte k = k[7:0] -> bus shows CMD 00h, then addresses 00h,00h,00h, then 512 bytes 00..FF,00..FF with rd_col 0..511. rd_last at col 511, done one cycle after its handshake, busy low the same cycle.
- page_addr=511 -> address bytes 00h,FFh,01h. Data matches flash_a Mem[261632..262143].
- rd_ready toggled 1-of-4 cycles -> no REN low pulse while a byte is held unaccepted. All 512 bytes delivered in order with none lost or duplicated. rd_data stable while stalled.
- Flash model holding F_RB=0 -> err pulse exactly RB_TIMEOUT cycles after WAIT_RB entry. busy=0, done never asserted, F_REN stays 1.
- rst=0 for one cycle at column 100 -> next cycle F_REN=1, F_WEN=1, F_IO=Z, rd_valid=0, busy=0. A new start on page 3 then completes normally.
- start held high throughout and re-pulsed mid-transfer -> exactly one command sequence per accepted start. A new read begins only from IDLE after done.
